// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx among NREQ requesters, with a per-owner bus lock.
// Grant/ack/tx_start appear one cycle after the sampling edge; waits on tx_ready, req must be held until ack.
module uart_tx_arbiter #(
    parameter int NREQ = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   lock,
    input  logic [8*NREQ-1:0] data,
    output logic [NREQ-1:0]   ack,
    output logic [NREQ-1:0]   grant,
    output logic              busy,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    input  logic              tx_ready
);

    localparam int IW = $clog2(NREQ);

    typedef enum logic [1:0] {
        ARB       = 2'd0,
        WAIT_BUSY = 2'd1,
        WAIT_DONE = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [IW-1:0]     last_q, last_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic [NREQ-1:0]   ack_q, ack_d;
    logic              busy_q, busy_d;
    logic              tx_start_q, tx_start_d;
    logic [7:0]        tx_data_q, tx_data_d;

    logic              owner_lock;
    logic              win_vld;
    logic [IW-1:0]     win_idx;
    logic [NREQ-1:0]   win_oh;

    function automatic logic [IW-1:0] rr_idx(input logic [IW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NREQ) s = s - NREQ;
        return s[IW-1:0];
    endfunction

    // A parked owner (grant held with lock) excludes everyone else, even with its req low.
    assign owner_lock = (|grant_q) && lock[last_q];

    always_comb begin
        win_vld = 1'b0;
        win_idx = last_q;
        if (owner_lock) begin
            win_vld = req[last_q];
        end else begin
            for (int i = 1; i <= NREQ; i++) begin
                if (!win_vld && req[rr_idx(last_q, i)]) begin
                    win_vld = 1'b1;
                    win_idx = rr_idx(last_q, i);
                end
            end
        end
    end

    assign win_oh = {{(NREQ-1){1'b0}}, 1'b1} << win_idx;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= ARB;
            last_q     <= IW'(NREQ-1);
            grant_q    <= '0;
            ack_q      <= '0;
            busy_q     <= 1'b0;
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'h00;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            grant_q    <= grant_d;
            ack_q      <= ack_d;
            busy_q     <= busy_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB:       if (tx_ready && win_vld) state_d = WAIT_BUSY;
            WAIT_BUSY: if (!tx_ready)           state_d = WAIT_DONE;
            WAIT_DONE: if (tx_ready)            state_d = ARB;
            default:                            state_d = ARB;
        endcase
    end

    always_comb begin
        last_d     = last_q;
        grant_d    = grant_q;
        ack_d      = '0;
        busy_d     = busy_q;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        case (state_q)
            ARB: begin
                if (tx_ready && win_vld) begin
                    tx_data_d  = data[{win_idx, 3'b000} +: 8];
                    tx_start_d = 1'b1;
                    ack_d      = win_oh;
                    grant_d    = win_oh;
                    last_d     = win_idx;
                    busy_d     = 1'b1;
                end else if (!owner_lock) begin
                    grant_d = '0;
                end
            end
            WAIT_DONE: begin
                if (tx_ready) begin
                    busy_d = 1'b0;
                    if (!lock[last_q]) grant_d = '0;
                end
            end
            default: ;
        endcase
    end

    assign ack      = ack_q;
    assign grant    = grant_q;
    assign busy     = busy_q;
    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;

    assert property (@(posedge clk) disable iff (!rstn) $onehot0(ack_q));
    assert property (@(posedge clk) disable iff (!rstn) $onehot0(grant_q));
    assert property (@(posedge clk) disable iff (!rstn)
                     (busy_q && $past(busy_q)) |-> $stable(tx_data_q));

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a behavioural uart_tx and serial receiver.
module tb_uart_tx_arbiter;

    localparam int NREQ = 4;
    localparam int BIT  = 4;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic [NREQ-1:0]   req = '0;
    logic [NREQ-1:0]   lock = '0;
    logic [8*NREQ-1:0] data = '0;
    logic [NREQ-1:0]   ack;
    logic [NREQ-1:0]   grant;
    logic              busy;
    logic              tx_start;
    logic [7:0]        tx_data;
    logic              tx_ready;

    logic              m_rdy = 1'b1;
    logic              txd = 1'b1;
    logic              force_busy = 1'b0;
    logic              m_act = 1'b0;
    logic [9:0]        m_sh = '0;
    int                m_cyc = 0;
    int                m_bit = 0;

    int n_chk  = 0;
    int n_fail = 0;
    logic [7:0] rx_q[$];
    logic       prev_busy = 1'b0;
    logic [7:0] prev_data = 8'h00;

    always #5 clk = ~clk;

    assign tx_ready = m_rdy & ~force_busy;

    uart_tx_arbiter #(.NREQ(NREQ)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .req      (req),
        .lock     (lock),
        .data     (data),
        .ack      (ack),
        .grant    (grant),
        .busy     (busy),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx_ready (tx_ready)
    );

    // uart_tx model: accepts start while ready, drops ready the next cycle, 8N1 frame of BIT cycles per bit.
    always @(posedge clk) begin
        if (!rstn) begin
            m_rdy <= 1'b1;
            txd   <= 1'b1;
            m_act <= 1'b0;
            m_cyc <= 0;
            m_bit <= 0;
        end else if (!m_act) begin
            if (tx_start && tx_ready) begin
                m_act <= 1'b1;
                m_sh  <= {1'b1, tx_data, 1'b0};
                txd   <= 1'b0;
                m_rdy <= 1'b0;
                m_cyc <= 0;
                m_bit <= 0;
            end
        end else if (m_cyc == BIT-1) begin
            m_cyc <= 0;
            if (m_bit == 9) begin
                m_act <= 1'b0;
                m_rdy <= 1'b1;
                txd   <= 1'b1;
            end else begin
                m_bit <= m_bit + 1;
                txd   <= m_sh[m_bit+1];
            end
        end else begin
            m_cyc <= m_cyc + 1;
        end
    end

    initial begin
        logic [7:0] b;
        forever begin
            @(negedge txd);
            repeat (BIT + BIT/2) @(negedge clk);
            for (int k = 0; k < 8; k++) begin
                b[k] = txd;
                repeat (BIT) @(negedge clk);
            end
            if (txd) rx_q.push_back(b);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rstn) begin
            chk("ack_onehot0", 32'($onehot0(ack)), 32'd1);
            chk("grant_onehot0", 32'($onehot0(grant)), 32'd1);
            if (tx_start) chk("start_with_ack", 32'(ack != '0), 32'd1);
            if (prev_busy && busy) chk("tx_data_stable", 32'(tx_data), 32'(prev_data));
        end
        prev_busy = busy && rstn;
        prev_data = tx_data;
    end

    task automatic wait_start(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (tx_start) break;
        end
        chk({tag, "_start"}, 32'(tx_start), 32'd1);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        chk({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        req = '0;
        lock = '0;
        force_busy = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset values
        repeat (2) @(negedge clk);
        chk("rst_ack", 32'(ack), 32'h0);
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_tx_start", 32'(tx_start), 32'h0);
        chk("rst_tx_data", 32'(tx_data), 32'h0);
        chk("rst_txd", 32'(txd), 32'h1);
        rstn = 1'b1;

        // 1: single byte, latency and framing
        rx_q.delete();
        @(negedge clk);
        data[7:0] = 8'h41;
        req = 4'b0001;
        @(negedge clk);
        chk("t1_ack", 32'(ack), 32'h1);
        chk("t1_tx_start", 32'(tx_start), 32'h1);
        chk("t1_tx_data", 32'(tx_data), 32'h41);
        chk("t1_busy", 32'(busy), 32'h1);
        req = 4'b0000;
        @(negedge clk);
        chk("t1_start_pulse", 32'(tx_start), 32'h0);
        chk("t1_ack_pulse", 32'(ack), 32'h0);
        wait_idle("t1", 100);
        chk("t1_grant_clear", 32'(grant), 32'h0);
        chk("t1_rx_count", 32'(rx_q.size()), 32'd1);
        if (rx_q.size() > 0) chk("t1_rx_byte", 32'(rx_q[0]), 32'h41);

        // 2: all request, round robin from requester 0
        do_reset();
        rx_q.delete();
        data = {8'h33, 8'h32, 8'h31, 8'h30};
        req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            wait_start("t2", 100);
            chk("t2_ack", 32'(ack), 32'(1 << (n % 4)));
            chk("t2_grant", 32'(grant), 32'(1 << (n % 4)));
            chk("t2_tx_data", 32'(tx_data), 32'h30 + 32'(n % 4));
        end
        req = 4'b0000;
        wait_idle("t2", 100);
        chk("t2_rx_count", 32'(rx_q.size()), 32'd5);
        for (int n = 0; n < 5 && n < rx_q.size(); n++)
            chk("t2_rx_byte", 32'(rx_q[n]), 32'h30 + 32'(n % 4));

        // 3: locked multi-byte message from requester 2
        do_reset();
        data = {8'h53, 8'hA0, 8'h51, 8'h50};
        lock = 4'b0100;
        req = 4'b0100;
        wait_start("t3a", 20);
        chk("t3a_ack", 32'(ack), 32'h4);
        chk("t3a_tx_data", 32'(tx_data), 32'hA0);
        data[23:16] = 8'hA1;
        req = 4'b0111;
        wait_start("t3b", 100);
        chk("t3b_ack", 32'(ack), 32'h4);
        chk("t3b_grant", 32'(grant), 32'h4);
        chk("t3b_tx_data", 32'(tx_data), 32'hA1);
        data[23:16] = 8'hA2;
        wait_start("t3c", 100);
        chk("t3c_ack", 32'(ack), 32'h4);
        chk("t3c_grant", 32'(grant), 32'h4);
        chk("t3c_tx_data", 32'(tx_data), 32'hA2);
        req = 4'b0011;
        wait_idle("t3", 100);

        // 4: parked owner blocks others
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("t4_no_start", 32'(tx_start), 32'h0);
            chk("t4_no_ack", 32'(ack), 32'h0);
            chk("t4_grant_parked", 32'(grant), 32'h4);
        end
        lock = 4'b0000;
        @(negedge clk);
        chk("t3_release_ack", 32'(ack), 32'h1);
        chk("t3_release_start", 32'(tx_start), 32'h1);
        chk("t3_release_data", 32'(tx_data), 32'h50);
        req = 4'b0000;
        wait_idle("t3d", 100);

        // 5: transmitter externally busy in ARB
        do_reset();
        force_busy = 1'b1;
        data[15:8] = 8'h55;
        req = 4'b0010;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t5_no_ack", 32'(ack), 32'h0);
            chk("t5_no_start", 32'(tx_start), 32'h0);
        end
        force_busy = 1'b0;
        @(negedge clk);
        chk("t5_ack", 32'(ack), 32'h2);
        chk("t5_tx_start", 32'(tx_start), 32'h1);
        chk("t5_tx_data", 32'(tx_data), 32'h55);
        req = 4'b0000;
        wait_idle("t5", 100);

        // 6: reset mid-frame
        do_reset();
        data[7:0] = 8'h66;
        req = 4'b0001;
        wait_start("t6", 20);
        chk("t6_tx_data", 32'(tx_data), 32'h66);
        req = 4'b0000;
        repeat (15) @(negedge clk);
        chk("t6_midframe_busy", 32'(busy), 32'h1);
        data[15:0] = {8'h88, 8'h77};
        req = 4'b0011;
        rstn = 1'b0;
        @(negedge clk);
        chk("t6_rst_ack", 32'(ack), 32'h0);
        chk("t6_rst_grant", 32'(grant), 32'h0);
        chk("t6_rst_busy", 32'(busy), 32'h0);
        chk("t6_rst_tx_start", 32'(tx_start), 32'h0);
        chk("t6_rst_tx_data", 32'(tx_data), 32'h0);
        chk("t6_rst_txd", 32'(txd), 32'h1);
        rstn = 1'b1;
        @(negedge clk);
        chk("t6_after_ack", 32'(ack), 32'h1);
        chk("t6_after_start", 32'(tx_start), 32'h1);
        chk("t6_after_data", 32'(tx_data), 32'h77);
        req = 4'b0000;
        wait_idle("t6", 100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
